// File: rtl/trace_frame_rx.sv
// UART result-frame receiver: reassembles PT, key and CT, stores the trace in a sample RAM
// and flags the first MARKER sample. Optional inter-byte timeout: define TRACE_RX_TIMEOUT_EN.
module trace_frame_rx #(
  parameter int          BLOCK_BYTES    = 4,
  parameter int          KEY_BYTES      = 8,
  parameter int          SAMPLES        = 1024,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  MARKER         = 8'hFF,
  localparam int         AW             = $clog2(SAMPLES),
  localparam int         PT_W           = 8 * BLOCK_BYTES,
  localparam int         KEY_W          = 8 * KEY_BYTES
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx_dv,
  input  logic [7:0]       rx_byte,
  output logic [PT_W-1:0]  pt,
  output logic [KEY_W-1:0] key,
  output logic [PT_W-1:0]  ct,
  input  logic [AW-1:0]    rd_addr,
  output logic [7:0]       rd_data,
  output logic             busy,
  output logic             frame_valid,
  output logic             frame_done,
  output logic             frame_err,
  output logic             marker_found,
  output logic [AW-1:0]    marker_idx
);

  localparam int MAX_FB = (KEY_BYTES > BLOCK_BYTES) ? KEY_BYTES : BLOCK_BYTES;
  localparam int MAXN   = (SAMPLES > MAX_FB) ? SAMPLES : MAX_FB;
  localparam int CW     = $clog2(MAXN) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PT, S_KEY, S_CT, S_TRACE, S_DONE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    byte_cnt_q;
  logic [PT_W-1:0]  pt_q;
  logic [KEY_W-1:0] key_q;
  logic [PT_W-1:0]  ct_q;
  logic             busy_q;
  logic             frame_valid_q;
  logic             frame_done_q;
  logic             marker_found_q;
  logic [AW-1:0]    marker_idx_q;
  logic [7:0]       rd_data_q;
  logic [7:0]       mem [SAMPLES];

`ifdef TRACE_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] idle_cnt_q;
  logic          frame_err_q;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= S_IDLE;
      byte_cnt_q     <= '0;
      pt_q           <= '0;
      key_q          <= '0;
      ct_q           <= '0;
      busy_q         <= 1'b0;
      frame_valid_q  <= 1'b0;
      frame_done_q   <= 1'b0;
      marker_found_q <= 1'b0;
      marker_idx_q   <= '0;
`ifdef TRACE_RX_TIMEOUT_EN
      idle_cnt_q     <= '0;
      frame_err_q    <= 1'b0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rx_dv) begin
            pt_q[PT_W-1 -: 8] <= rx_byte;
            frame_valid_q     <= 1'b0;
            marker_found_q    <= 1'b0;
            marker_idx_q      <= '0;
            busy_q            <= 1'b1;
            if (BLOCK_BYTES == 1) begin
              state_q    <= S_KEY;
              byte_cnt_q <= '0;
            end else begin
              state_q    <= S_PT;
              byte_cnt_q <= CW'(1);
            end
          end
        end
        S_PT: begin
          if (rx_dv) begin
            pt_q[PT_W-1-8*int'(byte_cnt_q) -: 8] <= rx_byte;
            if (byte_cnt_q == CW'(BLOCK_BYTES-1)) begin
              state_q    <= S_KEY;
              byte_cnt_q <= '0;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end
        S_KEY: begin
          if (rx_dv) begin
            key_q[KEY_W-1-8*int'(byte_cnt_q) -: 8] <= rx_byte;
            if (byte_cnt_q == CW'(KEY_BYTES-1)) begin
              state_q    <= S_CT;
              byte_cnt_q <= '0;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end
        S_CT: begin
          if (rx_dv) begin
            ct_q[PT_W-1-8*int'(byte_cnt_q) -: 8] <= rx_byte;
            if (byte_cnt_q == CW'(BLOCK_BYTES-1)) begin
              state_q    <= S_TRACE;
              byte_cnt_q <= '0;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end
        S_TRACE: begin
          if (rx_dv) begin
            if (rx_byte == MARKER && !marker_found_q) begin
              marker_found_q <= 1'b1;
              marker_idx_q   <= byte_cnt_q[AW-1:0];
            end
            if (byte_cnt_q == CW'(SAMPLES-1)) begin
              state_q       <= S_DONE;
              byte_cnt_q    <= '0;
              frame_done_q  <= 1'b1;
              frame_valid_q <= 1'b1;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
`ifdef TRACE_RX_TIMEOUT_EN
      // Placed after the FSM so an abort overrides any same-cycle field progress.
      frame_err_q <= 1'b0;
      if (busy_q) begin
        if (rx_dv) begin
          idle_cnt_q <= '0;
        end else if (idle_cnt_q == TW'(TIMEOUT_CYCLES-1)) begin
          frame_err_q  <= 1'b1;
          state_q      <= S_IDLE;
          busy_q       <= 1'b0;
          byte_cnt_q   <= '0;
          idle_cnt_q   <= '0;
          frame_done_q <= 1'b0;
        end else begin
          idle_cnt_q <= idle_cnt_q + 1'b1;
        end
      end else begin
        idle_cnt_q <= '0;
      end
`endif
    end
  end

  // Sample RAM: not reset, so contents survive a mid-frame reset.
  always_ff @(posedge clk) begin
    if (state_q == S_TRACE && rx_dv) begin
      mem[byte_cnt_q[AW-1:0]] <= rx_byte;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign pt           = pt_q;
  assign key          = key_q;
  assign ct           = ct_q;
  assign rd_data      = rd_data_q;
  assign busy         = busy_q;
  assign frame_valid  = frame_valid_q;
  assign frame_done   = frame_done_q;
  assign marker_found = marker_found_q;
  assign marker_idx   = marker_idx_q;
`ifdef TRACE_RX_TIMEOUT_EN
  assign frame_err    = frame_err_q;
`else
  assign frame_err    = 1'b0;
`endif

endmodule

// File: tb/tb_trace_frame_rx.sv
// Scoreboard bench for trace_frame_rx: expected frames queued at send time, compared on frame_done.
module tb_trace_frame_rx;
  localparam int NS    = 1024;
  localparam int AW    = 10;
  localparam int HDR   = 16;
  localparam int TOTAL = HDR + NS;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          rx_dv = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic [AW-1:0] rd_addr = '0;
  logic [31:0]   pt;
  logic [63:0]   key;
  logic [31:0]   ct;
  logic [7:0]    rd_data;
  logic          busy, frame_valid, frame_done, frame_err, marker_found;
  logic [AW-1:0] marker_idx;

  trace_frame_rx #(
    .BLOCK_BYTES(4), .KEY_BYTES(8), .SAMPLES(NS), .TIMEOUT_CYCLES(50), .MARKER(8'hFF)
  ) dut (
    .clk(clk), .rstn(rstn), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .pt(pt), .key(key), .ct(ct), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .frame_valid(frame_valid), .frame_done(frame_done),
    .frame_err(frame_err), .marker_found(marker_found), .marker_idx(marker_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   pt;
    logic [63:0]   key;
    logic [31:0]   ct;
    logic          mf;
    logic [AW-1:0] midx;
  } frame_t;

  frame_t exp_q[$];
  frame_t obs_q[$];
  frame_t mon_f;
  int tests = 0;
  int fails = 0;
  int err_pulses = 0;

  always @(negedge clk) begin
    if (frame_done) begin
      mon_f.pt = pt; mon_f.key = key; mon_f.ct = ct;
      mon_f.mf = marker_found; mon_f.midx = marker_idx;
      obs_q.push_back(mon_f);
    end
    if (frame_err) err_pulses++;
  end

  function automatic logic [7:0] frame_byte(input int i, input logic [31:0] p,
      input logic [63:0] k, input logic [31:0] c, input int m1, input int m2);
    int t;
    if (i < 4) return p[31-8*i -: 8];
    if (i < 12) return k[63-8*(i-4) -: 8];
    if (i < 16) return c[31-8*(i-12) -: 8];
    t = i - HDR;
    if (t == m1 || t == m2) return 8'hFF;
    return 8'(t % 250);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_dv = 1'b1;
    rx_byte = b;
    @(posedge clk); #1;
    rx_dv = 1'b0;
  endtask

  task automatic send_range(input logic [31:0] p, input logic [63:0] k, input logic [31:0] c,
      input int m1, input int m2, input int from, input int to);
    for (int i = from; i < to; i++) send_byte(frame_byte(i, p, k, c, m1, m2));
  endtask

  task automatic push_exp(input logic [31:0] p, input logic [63:0] k, input logic [31:0] c,
      input logic mf, input int midx);
    frame_t f;
    f.pt = p; f.key = k; f.ct = c; f.mf = mf; f.midx = AW'(midx);
    exp_q.push_back(f);
  endtask

  task automatic check_frame(input string name);
    frame_t e, o;
    for (int i = 0; i < 4 && obs_q.size() == 0; i++) begin
      @(posedge clk); #1;
    end
    tests++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s_done: got %0d pulses, required 1 (expected entries %0d)", name, obs_q.size(), exp_q.size());
      return;
    end
    e = exp_q.pop_front();
    o = obs_q.pop_front();
    tests++; if (o.pt !== e.pt) begin fails++; $display("FAIL %s_pt: got %h required %h", name, o.pt, e.pt); end
    tests++; if (o.key !== e.key) begin fails++; $display("FAIL %s_key: got %h required %h", name, o.key, e.key); end
    tests++; if (o.ct !== e.ct) begin fails++; $display("FAIL %s_ct: got %h required %h", name, o.ct, e.ct); end
    tests++; if (o.mf !== e.mf) begin fails++; $display("FAIL %s_marker_found: got %b required %b", name, o.mf, e.mf); end
    tests++; if (o.midx !== e.midx) begin fails++; $display("FAIL %s_marker_idx: got %0d required %0d", name, o.midx, e.midx); end
    $display("[TB] %s: frame pt=%h key=%h ct=%h marker=%b/%0d", name, o.pt, o.key, o.ct, o.mf, o.midx);
  endtask

  task automatic check_no_extra(input string name);
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL %s_extra_done: got %0d extra pulses, required 0", name, obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic check_read(input int addr, input logic [7:0] exp);
    rd_addr = AW'(addr);
    @(posedge clk); #1;
    tests++;
    if (rd_data !== exp) begin
      fails++;
      $display("FAIL read_%0d: got %h required %h", addr, rd_data, exp);
    end
    $display("[TB] read addr %0d -> %h", addr, rd_data);
  endtask

  task automatic check_reset_values(input string name);
    tests++;
    if ({pt, key, ct} !== '0 || rd_data !== 8'h00 || marker_idx !== '0 ||
        {busy, frame_valid, frame_done, frame_err, marker_found} !== 5'b0) begin
      fails++;
      $display("FAIL %s: got pt=%h key=%h ct=%h rd=%h flags=%b idx=%0d required all zero", name,
               pt, key, ct, rd_data, {busy, frame_valid, frame_done, frame_err, marker_found}, marker_idx);
    end
    $display("[TB] %s checked", name);
  endtask

  task automatic test_reset();
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_frame();
    send_range(32'h01020304, 64'h1918111009080100, 32'hA1B2C3D4, -1, -1, 0, TOTAL);
    push_exp(32'h01020304, 64'h1918111009080100, 32'hA1B2C3D4, 1'b0, 0);
    @(posedge clk); #1;
    check_frame("full");
    tests++;
    if (frame_valid !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL full_status: got valid=%b busy=%b required valid=1 busy=0", frame_valid, busy);
    end
    check_no_extra("full");
    check_read(0, 8'd0);
    check_read(500, 8'd0);
    check_read(249, 8'd249);
    check_read(1023, 8'd23);
  endtask

  task automatic test_marker();
    send_range(32'h01020304, 64'h1918111009080100, 32'hA1B2C3D4, 700, 900, 0, TOTAL);
    push_exp(32'h01020304, 64'h1918111009080100, 32'hA1B2C3D4, 1'b1, 700);
    @(posedge clk); #1;
    check_frame("marker");
    check_read(700, 8'hFF);
    check_read(900, 8'hFF);
  endtask

  task automatic test_back_to_back();
    send_range(32'h11223344, 64'h0123456789ABCDEF, 32'h55667788, -1, -1, 0, TOTAL);
    push_exp(32'h11223344, 64'h0123456789ABCDEF, 32'h55667788, 1'b0, 0);
    @(posedge clk); #1;
    tests++;
    if (frame_valid !== 1'b1) begin
      fails++;
      $display("FAIL b2b_valid_first: got %b required 1", frame_valid);
    end
    send_range(32'hDEADBEEF, 64'hCAFEF00D12345678, 32'h0BADC0DE, 5, -1, 0, 1);
    tests++;
    if (frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_valid_drop: got %b required 0", frame_valid);
    end
    send_range(32'hDEADBEEF, 64'hCAFEF00D12345678, 32'h0BADC0DE, 5, -1, 1, TOTAL);
    push_exp(32'hDEADBEEF, 64'hCAFEF00D12345678, 32'h0BADC0DE, 1'b1, 5);
    @(posedge clk); #1;
    check_frame("b2b_a");
    check_frame("b2b_b");
    check_no_extra("b2b");
  endtask

  task automatic test_reset_mid();
    send_range(32'h0F0E0D0C, 64'h7766554433221100, 32'h89ABCDEF, 100, -1, 0, HDR + 301);
    tests++;
    if (marker_found !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL midreset_pre: got marker=%b busy=%b required 1/1", marker_found, busy);
    end
    rstn = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    send_range(32'hA5A5A5A5, 64'h5A5A5A5A5A5A5A5A, 32'h3C3C3C3C, 333, -1, 0, TOTAL);
    push_exp(32'hA5A5A5A5, 64'h5A5A5A5A5A5A5A5A, 32'h3C3C3C3C, 1'b1, 333);
    @(posedge clk); #1;
    check_frame("after_reset");
  endtask

  task automatic test_stall();
    int err0;
    send_range(32'hCCDDEEFF, 64'h0011223344556677, 32'h8899AABB, -1, -1, 0, 8);
    err0 = err_pulses;
    repeat (60) @(posedge clk);
    #1;
`ifdef TRACE_RX_TIMEOUT_EN
    tests++;
    if (err_pulses - err0 !== 1) begin
      fails++;
      $display("FAIL timeout_err: got %0d pulses required 1", err_pulses - err0);
    end
    tests++;
    if (busy !== 1'b0 || frame_valid !== 1'b0) begin
      fail_status: begin
        fails++;
        $display("FAIL timeout_status: got busy=%b valid=%b required 0/0", busy, frame_valid);
      end
    end
    send_range(32'h13579BDF, 64'h2468ACE013579BDF, 32'hFEDCBA98, -1, -1, 0, TOTAL);
    push_exp(32'h13579BDF, 64'h2468ACE013579BDF, 32'hFEDCBA98, 1'b0, 0);
`else
    tests++;
    if (err_pulses - err0 !== 0) begin
      fails++;
      $display("FAIL stall_err: got %0d pulses required 0", err_pulses - err0);
    end
    tests++;
    if (busy !== 1'b1 || frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall_status: got busy=%b valid=%b required 1/0", busy, frame_valid);
    end
    send_range(32'hCCDDEEFF, 64'h0011223344556677, 32'h8899AABB, -1, -1, 8, TOTAL);
    push_exp(32'hCCDDEEFF, 64'h0011223344556677, 32'h8899AABB, 1'b0, 0);
`endif
    @(posedge clk); #1;
    check_frame("after_stall");
    check_no_extra("after_stall");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_marker();
    test_back_to_back();
    test_reset_mid();
    test_stall();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover_expected: got %0d entries required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

endmodule
